// File: rtl/serial_magnitude_comparator.sv
// Serial unsigned magnitude comparator: walks 2-bit slices MSB-first, one slice per clock.
// Define SERIAL_CMP_EARLY_EXIT_EN to stop on the first unequal slice; default is constant-time.
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NSLICE = WIDTH / 2;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDXW-1:0]  r_idx;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;
  logic             r_decided;

  logic [1:0]       w_sa;
  logic [1:0]       w_sb;
  logic             w_ne;
  logic             w_finish;
  logic             w_accept;

  // Slice mux written as a loop so the index never needs a width-mismatched multiply.
  always_comb begin
    w_sa = '0;
    w_sb = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_sa = r_a[2*i +: 2];
        w_sb = r_b[2*i +: 2];
      end
    end
  end

  assign w_ne     = (w_sa != w_sb);
  assign w_accept = start && (r_state != S_RUN);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign w_finish = (r_idx == '0) || w_ne;
`else
  assign w_finish = (r_idx == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_finish) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_gt      <= 1'b0;
      r_eq      <= 1'b0;
      r_lt      <= 1'b0;
      r_decided <= 1'b0;
    end else if (w_accept) begin
      r_a       <= a;
      r_b       <= b;
      r_idx     <= IDXW'(NSLICE - 1);
      r_gt      <= 1'b0;
      r_eq      <= 1'b0;
      r_lt      <= 1'b0;
      r_decided <= 1'b0;
    end else if (r_state == S_RUN) begin
      // First differing slice wins; later slices are still walked but cannot override it.
      if (!r_decided && w_ne) begin
        r_gt      <= (w_sa > w_sb);
        r_lt      <= (w_sa < w_sb);
        r_decided <= 1'b1;
      end
      if (w_finish) r_eq <= !r_decided && !w_ne;
      else          r_idx <= r_idx - 1'b1;
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign gt   = r_gt;
  assign eq   = r_eq;
  assign lt   = r_lt;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator (WIDTH=8); expectations are hand-computed
// per vector, with latency picked according to SERIAL_CMP_EARLY_EXIT_EN.
module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       gt;
  logic       eq;
  logic       lt;

  serial_magnitude_comparator #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .gt   (gt),
    .eq   (eq),
    .lt   (lt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  flags;
    int unsigned lat;
  } exp_t;

  localparam logic [2:0] F_GT = 3'b100;
  localparam logic [2:0] F_EQ = 3'b010;
  localparam logic [2:0] F_LT = 3'b001;

  exp_t        q[$];
  int unsigned checks   = 0;
  int unsigned errors   = 0;
  int unsigned run_cnt  = 0;
  int unsigned done_cnt = 0;
  int unsigned pushed   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned pick(input int unsigned lat_early, input int unsigned lat_full);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    return lat_early;
`else
    return lat_full;
`endif
  endfunction

  task automatic push(input logic [2:0] f, input int unsigned lat);
    exp_t e;
    e.flags = f;
    e.lat   = lat;
    q.push_back(e);
    pushed++;
  endtask

  // Monitor: counts RUN cycles and checks every done pulse against the scoreboard.
  always @(negedge clk) begin
    if (busy) run_cnt++;
    if (done) begin
      exp_t e;
      done_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("result_flags", {29'd0, gt, eq, lt}, {29'd0, e.flags});
        chk("run_latency", run_cnt, e.lat);
      end
      run_cnt = 0;
    end else if (!busy) begin
      run_cnt = 0;
    end
  end

  task automatic wait_idle();
    int unsigned n = 0;
    while ((busy || done) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_cmp(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] f,
                        input int unsigned lat_early, input int unsigned lat_full);
    push(f, pick(lat_early, lat_full));
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_idle();
    chk("flags_hold_idle", {29'd0, gt, eq, lt}, {29'd0, f});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned dsnap;
    logic [7:0] pa[4];
    logic [7:0] pb[4];
    logic [2:0] pf[4];
    int unsigned pl[4];

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    rst = 1'b0;

    do_cmp(8'hA5, 8'hA5, F_EQ, 4, 4);
    do_cmp(8'h80, 8'h7F, F_GT, 1, 4);
    do_cmp(8'h12, 8'h13, F_LT, 4, 4);

    // Start pulses and operand changes during RUN must be ignored.
    dsnap = done_cnt;
    push(F_GT, 4);
    @(negedge clk);
    a = 8'h01; b = 8'h00; start = 1'b1;
    @(negedge clk);
    a = 8'h00; b = 8'hFF;
    @(negedge clk);
    start = 1'b0; a = 8'hFF; b = 8'h00;
    @(negedge clk);
    start = 1'b1; a = 8'h00; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("ignored_start_flags", {29'd0, gt, eq, lt}, {29'd0, F_GT});
    chk("single_done_pulse", done_cnt - dsnap, 32'd1);

    // Reset in the second RUN cycle abandons the comparison.
    dsnap = done_cnt;
    @(negedge clk);
    a = 8'h00; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt - dsnap, 32'd0);
    do_cmp(8'h00, 8'hFF, F_LT, 1, 4);

    // Start held high: each DONE cycle accepts the next pair directly.
    pa[0] = 8'hA5; pb[0] = 8'h5A; pf[0] = F_GT; pl[0] = pick(1, 4);
    pa[1] = 8'h3C; pb[1] = 8'h3D; pf[1] = F_LT; pl[1] = 4;
    pa[2] = 8'hA5; pb[2] = 8'h5A; pf[2] = F_GT; pl[2] = pick(1, 4);
    pa[3] = 8'h3C; pb[3] = 8'h3D; pf[3] = F_LT; pl[3] = 4;
    dsnap = done_cnt;
    @(negedge clk);
    push(pf[0], pl[0]);
    a = pa[0]; b = pb[0]; start = 1'b1;
    @(negedge clk);
    for (int k = 1; k < 4; k++) begin
      wait_done();
      chk("b2b_done_not_busy", {31'd0, busy}, 32'd0);
      a = pa[k]; b = pb[k];
      push(pf[k], pl[k]);
      @(negedge clk);
      chk("b2b_no_idle_gap", {30'd0, busy, done}, 32'd2);
    end
    wait_done();
    start = 1'b0;
    wait_idle();
    chk("b2b_done_count", done_cnt - dsnap, 32'd4);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q.size(), 32'd0);
    chk("total_done_count", done_cnt, pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_comparator.md
SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; the value SHALL be even and at least 2.
REQ-002 The block SHALL derive NSLICE = WIDTH/2, the number of 2-bit slices; slice i is bits [2i+1:2i].
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a comparison; sampled only when busy=0.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A, captured on the accepted start.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B, captured on the accepted start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a comparison is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse when the result becomes valid.
REQ-010 The block SHALL have ports gt, eq and lt, each output, 1 bit: the result flags A>B, A==B and A<B (unsigned).

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-012 Start acceptance: start=1 with busy=0 (IDLE or DONE) SHALL register a and b, set the slice index to NSLICE-1, clear gt/eq/lt to 0 and enter RUN.
REQ-013 Each RUN cycle SHALL compare one 2-bit slice of the registered operands, MSB slice first, as an unsigned 2-bit greater-than/less-than/equal.
REQ-014 Unequal slice: the block SHALL latch the result (gt=1 if A slice > B slice, else lt=1) into a sticky decided flag.
REQ-015 After the index-0 slice, or on early exit (REQ-026), the block SHALL enter DONE; if no slice differed, it SHALL set eq=1.
REQ-016 Otherwise the block SHALL decrement the slice index and stay in RUN; once a decision is latched, later slices SHALL NOT change it.
REQ-017 DONE SHALL last exactly one cycle with done=1, busy=0; it then returns to IDLE unless start is accepted that cycle.
REQ-018 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-019 Exactly one of gt/eq/lt SHALL be 1 from DONE onward; the flags hold until the next accepted start or reset.
REQ-020 start while busy=1 SHALL be ignored; a and b changes while busy SHALL NOT affect the result.
REQ-021 Latency without early exit: done SHALL be high in cycle NSLICE+1 after the start-accepting edge, i.e. start at edge 0 gives done after edge NSLICE.
REQ-022 Back-to-back: a start accepted in the DONE cycle SHALL enter RUN directly, with no IDLE cycle in between.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE with busy=0, done=0, gt=0, eq=0, lt=0, and clear the slice index and operand registers to 0.
REQ-024 rst SHALL override start in the same cycle; a comparison interrupted mid-RUN SHALL be abandoned with no done pulse.

Configuration
REQ-025 Macro SERIAL_CMP_EARLY_EXIT_EN SHALL select the termination policy.
REQ-026 With SERIAL_CMP_EARLY_EXIT_EN defined, the block SHALL enter DONE on the edge that evaluates the first unequal slice; latency is 1 + (number of leading equal slices), capped at NSLICE.
REQ-027 Without SERIAL_CMP_EARLY_EXIT_EN, every comparison SHALL take exactly NSLICE RUN cycles regardless of data (constant-time).

Verification (WIDTH=8, NSLICE=4)
REQ-028 The bench SHALL check: a=8'hA5, b=8'hA5, start pulse -> eq=1, gt=lt=0, done after 4 RUN cycles (both configurations).
REQ-029 The bench SHALL check: a=8'h80, b=8'h7F -> gt=1; done after 1 RUN cycle with SERIAL_CMP_EARLY_EXIT_EN, after 4 without.
REQ-030 The bench SHALL check: a=8'h12, b=8'h13 -> lt=1 from the final slice, done after 4 RUN cycles (both configurations).
REQ-031 The bench SHALL check: start with a=8'h01, b=8'h00, then start pulses and changes a/b during RUN -> ignored; result gt=1 with a single done pulse.
REQ-032 The bench SHALL check: rst=1 in the 2nd RUN cycle -> next cycle busy=0, flags=0, no done; a following start with a=8'h00, b=8'hFF gives lt=1.
REQ-033 The bench SHALL check: start held high continuously with alternating operand pairs -> a new comparison is accepted in each DONE cycle, and one done pulse is produced per comparison.
